// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - opcode constants, state enum and register-usage decode for the 4-stage pipeline
package pipeline_pkg;

    localparam logic [7:0] NOP = 8'h0A;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [2:0] OP_ORI   = 3'b111;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // {valid, reg}; ORI always targets R1
    function automatic logic [2:0] dest_of(input logic [7:0] ir);
        logic [2:0] d;
        d = 3'b000;
        if (ir[2:0] == OP_ORI)
            d = {1'b1, 2'b01};
        else if (ir[2:0] == OP_SHIFT)
            d = {1'b1, ir[7:6]};
        else if (ir[3:0] == OP_LOAD || ir[3:0] == OP_ADD ||
                 ir[3:0] == OP_SUB  || ir[3:0] == OP_NAND)
            d = {1'b1, ir[7:6]};
        return d;
    endfunction

    // {v1, r1, v2, r2}
    function automatic logic [5:0] srcs_of(input logic [7:0] ir);
        logic [5:0] s;
        s = 6'b000000;
        if (ir[2:0] == OP_ORI)
            s = {1'b1, 2'b01, 3'b000};
        else if (ir[2:0] == OP_SHIFT)
            s = {1'b1, ir[7:6], 3'b000};
        else if (ir[3:0] == OP_LOAD)
            s = {1'b1, ir[5:4], 3'b000};
        else if (ir[3:0] == OP_ADD  || ir[3:0] == OP_SUB ||
                 ir[3:0] == OP_NAND || ir[3:0] == OP_STORE)
            s = {1'b1, ir[7:6], 1'b1, ir[5:4]};
        return s;
    endfunction

    function automatic logic is_stop(input logic [7:0] ir);
        return ir[3:0] == OP_STOP;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - RAW hazard compare of the register-read stage against execute/writeback
module pipe_hazard_detect
    import pipeline_pkg::*;
(
    input  logic [7:0] ir_2,
    input  logic [7:0] ir_3,
    input  logic [7:0] ir_4,
    output logic       hazard
);

    logic [5:0] src;
    logic [2:0] dst3;
    logic [2:0] dst4;

    always_comb begin
        src  = srcs_of(ir_2);
        dst3 = dest_of(ir_3);
        dst4 = dest_of(ir_4);
        // No RF write-through, so a writeback-stage producer still counts
        hazard = (src[5] && dst3[2] && src[4:3] == dst3[1:0]) ||
                 (src[5] && dst4[2] && src[4:3] == dst4[1:0]) ||
                 (src[2] && dst3[2] && src[1:0] == dst3[1:0]) ||
                 (src[2] && dst4[2] && src[1:0] == dst4[1:0]);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline sequencing: stall on RAW, flush on taken branch, drain and halt on STOP
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int STATW = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       ir_1,
    input  logic [7:0]       ir_2,
    input  logic [7:0]       ir_3,
    input  logic [7:0]       ir_4,
    input  logic             branch_taken,
    output logic             pc_load,
    output logic             pc1_load,
    output logic             pc2_load,
    output logic             pc3_load,
    output logic             ir1_load,
    output logic             ir2_load,
    output logic             ir3_load,
    output logic             ir4_load,
    output logic             ir1_nop,
    output logic             ir2_nop,
    output logic             ir3_nop,
    output logic             counter_on,
    output logic             halted,
    output logic [STATW-1:0] stall_cnt,
    output logic [STATW-1:0] flush_cnt
);

    localparam logic [STATW-1:0] CNT_ONE = 1;

    state_t state;
    state_t state_next;
    logic   hazard;
    logic   stall_inc;
    logic   flush_inc;

    pipe_hazard_detect u_hazard (
        .ir_2   (ir_2),
        .ir_3   (ir_3),
        .ir_4   (ir_4),
        .hazard (hazard)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    always_comb begin
        pc_load    = 1'b0;
        pc1_load   = 1'b0;
        pc2_load   = 1'b0;
        pc3_load   = 1'b0;
        ir1_load   = 1'b0;
        ir2_load   = 1'b0;
        ir3_load   = 1'b0;
        ir4_load   = 1'b0;
        ir1_nop    = 1'b0;
        ir2_nop    = 1'b0;
        ir3_nop    = 1'b0;
        counter_on = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_next = state;

        if (!reset) begin
            case (state)
                RUN, DRAIN: begin
                    counter_on = 1'b1;
                    if (branch_taken) begin
                        // Flush cancels any STOP being drained
                        {pc_load, pc1_load, pc2_load, pc3_load} = 4'b1111;
                        {ir1_load, ir2_load, ir3_load, ir4_load} = 4'b1111;
                        ir1_nop    = 1'b1;
                        ir2_nop    = 1'b1;
                        flush_inc  = 1'b1;
                        state_next = RUN;
                    end else if (hazard) begin
                        // Freeze fetch/read, bubble into execute, let older work retire
                        pc3_load  = 1'b1;
                        ir3_load  = 1'b1;
                        ir3_nop   = 1'b1;
                        ir4_load  = 1'b1;
                        ir1_nop   = (state == DRAIN);
                        stall_inc = 1'b1;
                    end else begin
                        {pc_load, pc1_load, pc2_load, pc3_load} = 4'b1111;
                        {ir1_load, ir2_load, ir3_load, ir4_load} = 4'b1111;
                        if (state == DRAIN) begin
                            pc_load  = 1'b0;
                            pc1_load = 1'b0;
                            ir1_nop  = 1'b1;
                            if (is_stop(ir_4))
                                state_next = HALTED;
                        end else if (is_stop(ir_1)) begin
                            pc_load    = 1'b0;
                            pc1_load   = 1'b0;
                            ir1_nop    = 1'b1;
                            state_next = DRAIN;
                        end
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with directed vectors
module tb_pipeline_hazard_ctrl;

    // {pc,pc1,pc2,pc3, ir1,ir2,ir3,ir4, ir1_nop,ir2_nop,ir3_nop, counter_on,halted}
    localparam logic [12:0] V_RESET  = 13'b0000_0000_000_00;
    localparam logic [12:0] V_NORMAL = 13'b1111_1111_000_10;
    localparam logic [12:0] V_STALL  = 13'b0001_0011_001_10;
    localparam logic [12:0] V_STALLD = 13'b0001_0011_101_10;
    localparam logic [12:0] V_FLUSH  = 13'b1111_1111_110_10;
    localparam logic [12:0] V_DRAIN  = 13'b0011_1111_100_10;
    localparam logic [12:0] V_HALT   = 13'b0000_0000_000_01;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ir_1 = 8'h0A;
    logic [7:0]  ir_2 = 8'h0A;
    logic [7:0]  ir_3 = 8'h0A;
    logic [7:0]  ir_4 = 8'h0A;
    logic        branch_taken = 1'b0;
    logic        pc_load, pc1_load, pc2_load, pc3_load;
    logic        ir1_load, ir2_load, ir3_load, ir4_load;
    logic        ir1_nop, ir2_nop, ir3_nop;
    logic        counter_on, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic [12:0] act;

    typedef struct {
        int          id;
        logic [12:0] ctrl;
        logic [15:0] s;
        logic [15:0] f;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    pipeline_hazard_ctrl #(.STATW(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .ir_1         (ir_1),
        .ir_2         (ir_2),
        .ir_3         (ir_3),
        .ir_4         (ir_4),
        .branch_taken (branch_taken),
        .pc_load      (pc_load),
        .pc1_load     (pc1_load),
        .pc2_load     (pc2_load),
        .pc3_load     (pc3_load),
        .ir1_load     (ir1_load),
        .ir2_load     (ir2_load),
        .ir3_load     (ir3_load),
        .ir4_load     (ir4_load),
        .ir1_nop      (ir1_nop),
        .ir2_nop      (ir2_nop),
        .ir3_nop      (ir3_nop),
        .counter_on   (counter_on),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clock = ~clock;

    assign act = {pc_load, pc1_load, pc2_load, pc3_load,
                  ir1_load, ir2_load, ir3_load, ir4_load,
                  ir1_nop, ir2_nop, ir3_nop, counter_on, halted};

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 3;
            if (act !== e.ctrl) begin
                errors = errors + 1;
                $display("FAIL step%0d ctrl got %b expected %b", e.id, act, e.ctrl);
            end
            if (stall_cnt !== e.s) begin
                errors = errors + 1;
                $display("FAIL step%0d stall_cnt got %0d expected %0d", e.id, stall_cnt, e.s);
            end
            if (flush_cnt !== e.f) begin
                errors = errors + 1;
                $display("FAIL step%0d flush_cnt got %0d expected %0d", e.id, flush_cnt, e.f);
            end
        end
    end

    task automatic step(input logic r, input logic b,
                        input logic [7:0] i1, input logic [7:0] i2,
                        input logic [7:0] i3, input logic [7:0] i4,
                        input logic [12:0] ctrl, input int s, input int f);
        exp_t e;
        reset        = r;
        branch_taken = b;
        ir_1 = i1;
        ir_2 = i2;
        ir_3 = i3;
        ir_4 = i4;
        e.id   = step_id;
        e.ctrl = ctrl;
        e.s    = 16'(s);
        e.f    = 16'(f);
        q.push_back(e);
        step_id = step_id + 1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        step(1, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_RESET,  0, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_NORMAL, 0, 0);
        // ADD R1,R2 in execute vs SUB R1,R3 in read
        step(0, 0, 8'h0A, 8'h76, 8'h64, 8'h0A, V_STALL,  0, 0);
        step(0, 0, 8'h0A, 8'h76, 8'h64, 8'h0A, V_STALL,  1, 0);
        step(0, 0, 8'h0A, 8'h76, 8'h64, 8'h0A, V_STALL,  2, 0);
        step(0, 0, 8'h0A, 8'h76, 8'h0A, 8'h0A, V_NORMAL, 3, 0);
        // LOAD R1 in writeback vs ORI reading R1
        step(0, 0, 8'h0A, 8'h17, 8'h0A, 8'h40, V_STALL,  3, 0);
        step(0, 0, 8'h0A, 8'h17, 8'h0A, 8'h0A, V_NORMAL, 4, 0);
        // SHIFT R0 does not collide with ADD R1,R2; SHIFT R2 does
        step(0, 0, 8'h0A, 8'h64, 8'h03, 8'h0A, V_NORMAL, 4, 0);
        step(0, 0, 8'h0A, 8'h64, 8'h83, 8'h0A, V_STALL,  4, 0);
        // LOAD R0 reads ir[5:4]=R0 against LOAD R0 in execute
        step(0, 0, 8'h0A, 8'h00, 8'h00, 8'h0A, V_STALL,  5, 0);
        // flush beats stall
        step(0, 1, 8'h0A, 8'h76, 8'h64, 8'h0A, V_FLUSH,  6, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_NORMAL, 6, 1);
        // STOP drains then halts
        step(0, 0, 8'h01, 8'h0A, 8'h0A, 8'h0A, V_DRAIN,  6, 1);
        step(0, 0, 8'h0A, 8'h01, 8'h0A, 8'h0A, V_DRAIN,  6, 1);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h01, V_DRAIN,  6, 1);
        step(0, 1, 8'h0A, 8'h76, 8'h64, 8'h0A, V_HALT,   6, 1);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_HALT,   6, 1);
        // reset out of HALTED
        step(1, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_RESET,  0, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_NORMAL, 0, 0);
        // stall and flush during DRAIN; flush returns to RUN
        step(0, 0, 8'h01, 8'h0A, 8'h0A, 8'h0A, V_DRAIN,  0, 0);
        step(0, 0, 8'h0A, 8'h76, 8'h64, 8'h0A, V_STALLD, 0, 0);
        step(0, 1, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_FLUSH,  1, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_NORMAL, 1, 1);
        // reset mid-drain
        step(0, 0, 8'h01, 8'h0A, 8'h0A, 8'h0A, V_DRAIN,  1, 1);
        step(1, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_RESET,  0, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h01, V_NORMAL, 0, 0);
        step(0, 0, 8'h0A, 8'h0A, 8'h0A, 8'h0A, V_NORMAL, 0, 0);
        repeat (3) @(posedge clock);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain pending %0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 4-stage 8-bit pipelined processor: IR_1 fetch, IR_2 register read, IR_3 execute/memory, IR_4 writeback.
- Generates every load/enable for PC, PC1–PC3 and IR_1–IR_4, plus NOP-injection selects.
- Resolves RAW hazards by stalling, taken branches by flushing, and STOP by draining and halting.
- Owns the performance-counter enable and a stall/flush statistics counter.

Parameters:
- NOP, 8'h0A, encoding injected as a bubble; IR registers reset to this value.
- STATW, 16, width of stall_cnt and flush_cnt.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high.
- ir_1  in  8  instruction in fetch latch.
- ir_2  in  8  instruction in register-read stage.
- ir_3  in  8  instruction in execute stage.
- ir_4  in  8  instruction in writeback stage.
- branch_taken  in  1  from stage-3 control; IR_3 is a branch whose condition is true this cycle.
- pc_load  out  1  PC register enable.
- pc1_load, pc2_load, pc3_load  out  1 each  PC pipeline enables.
- ir1_load, ir2_load, ir3_load, ir4_load  out  1 each  IR pipeline enables.
- ir1_nop, ir2_nop, ir3_nop  out  1 each  the corresponding IR loads NOP instead of its normal data.
- counter_on  out  1  performance-counter enable.
- halted  out  1  processor stopped.
- stall_cnt  out  STATW  cycles spent stalled.
- flush_cnt  out  STATW  taken-branch flushes.

Behaviour:
- Decode is by op = ir[3:0]. 3-bit ops match on ir[2:0]:
  - LOAD 0000, STORE 0010, ADD 0100, SUB 0110, NAND 1000.
  - ORI x111, SHIFT x011.
  - BZ 0101, BNZ 1001, BPZ 1101, STOP 0001, NOP 1010.
- Destination register:
  - LOAD/ADD/SUB/NAND/SHIFT write ir[7:6].
  - ORI writes R1.
  - All others write nothing.
- Source registers:
  - ADD/SUB/NAND/STORE read ir[7:6] and ir[5:4].
  - LOAD reads ir[5:4].
  - SHIFT reads ir[7:6].
  - ORI reads R1.
  - Branch/STOP/NOP read none.
- The RF has no write-through. hazard = any source of ir_2 equals a destination of ir_3 or ir_4.
- Outputs are combinational from state, hazard and branch_taken. Counters and state are registered.
- FSM states: RUN, DRAIN, HALTED. Reset → RUN, stall_cnt = 0, flush_cnt = 0.
- Outputs while reset is asserted: all loads 0, all nop selects 0, counter_on 0, halted 0.
- Priority per cycle (highest first): flush, stall, normal.
- Flush (branch_taken = 1, RUN or DRAIN):
  - pc_load = 1 (target via PCSel); ir1_nop = 1, ir2_nop = 1; all other loads = 1.
  - flush_cnt += 1; next state = RUN (a STOP being drained is cancelled).
- Stall (hazard = 1, no flush):
  - pc_load = 0, pc1_load = 0, ir1_load = 0, ir2_load = 0.
  - ir3_load = 1 with ir3_nop = 1; pc2_load = 0; pc3_load = 1; ir4_load = 1.
  - stall_cnt += 1; state unchanged.
- Normal in RUN: all loads 1, nop selects 0.
  - If op(ir_1) = STOP: pc_load = 0, pc1_load = 0, ir1_nop = 1; next state = DRAIN.
- DRAIN: pc_load = 0, pc1_load = 0, ir1_nop = 1; stalls and flushes still apply.
  - When op(ir_4) = STOP: next state = HALTED.
- HALTED: all loads 0, counter_on 0, halted 1. Exit only by reset.
- counter_on = 1 in RUN and DRAIN.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-drain: immediate return to RUN, counters cleared.

Decomposition:
- Package pipeline_pkg holds:
  - opcode constants and the NOP constant;
  - the state enum {RUN, DRAIN, HALTED};
  - functions dest_of(ir) → {valid, reg[1:0]} and srcs_of(ir) → {v1, r1, v2, r2}.
- One sub-module, pipe_hazard_detect: purely combinational compare of ir_2 against ir_3/ir_4, producing hazard.
- FSM and counters live in the top.

Test Plan:
- Reset, then all IRs = 8'h0A: RUN, all loads 1, counter_on 1, hazard 0, counters 0.
- ir_3 = 8'h64 (ADD R1,R2), ir_2 = 8'h76 (SUB R1,R3) → pc_load 0, ir2_load 0, ir3_nop 1, stall_cnt increments 1 per cycle until ir_3/ir_4 are cleared.
- ir_4 = 8'h40 (LOAD R1,(R0)), ir_2 = 8'h17 (ORI reads R1) → stall. ir_4 = 8'h0A → no stall.
- branch_taken = 1 together with hazard = 1 → flush wins: pc_load 1, ir1_nop 1, ir2_nop 1, flush_cnt 1, stall_cnt unchanged.
- ir_1 = 8'h01 (STOP) → DRAIN, pc_load 0. Advance ir_4 = 8'h01 → HALTED next edge: halted 1, counter_on 0, all loads 0.
- STOP in DRAIN, then branch_taken = 1 → back to RUN, pc_load 1. Assert reset while HALTED → RUN, counters 0.
